test_host: RTL

TEST_HOST -- requirements
Module: test_host

---
 rtl/host_pkg.sv | 28 ++
 rtl/test_host_if.sv | 38 +++
 rtl/host_cnt.sv | 34 +++
 rtl/test_host.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/host_pkg.sv
`default_nettype none
// =============================================================================
// Module      : host_pkg
// Description : Shared state encoding and default constants for test_host.
// Revision    : 1.0 - initial release
// =============================================================================
package host_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        RD    = 3'd4,
        CAP   = 3'd5,
        OUT   = 3'd6,
        FIN   = 3'd7
    } host_state_t;

    localparam logic [7:0]  c_load_base_dflt = 8'h00;
    localparam int          c_load_len_dflt  = 16;
    localparam logic [7:0]  c_res_base_dflt  = 8'h80;
    localparam int          c_res_len_dflt   = 4;
    localparam int          c_start_cyc_dflt = 2;
    localparam int          c_timeout_dflt   = 4096;

endpackage
`default_nettype wire

// File: rtl/test_host_if.sv
`default_nettype none
// =============================================================================
// Module      : test_host_if
// Description : Preload, memory, CPU-control, read-back and status signals.
// Revision    : 1.0 - initial release
// =============================================================================
interface test_host_if;
    logic       go;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       start;
    logic       halt;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
    logic       busy;
    logic       done;
    logic       timeout;

    modport master (
        input  go, ld_valid, ld_data, mem_rdata, halt, res_ready,
        output ld_ready, mem_we, mem_re, mem_addr, mem_wdata, start,
               res_valid, res_data, busy, done, timeout
    );

    modport slave (
        output go, ld_valid, ld_data, mem_rdata, halt, res_ready,
        input  ld_ready, mem_we, mem_re, mem_addr, mem_wdata, start,
               res_valid, res_data, busy, done, timeout
    );
endinterface
`default_nettype wire

// File: rtl/host_cnt.sv
`default_nettype none
// =============================================================================
// Module      : host_cnt
// Description : Loadable up-counter with terminal-count compare flag.
// Revision    : 1.0 - initial release
// =============================================================================
module host_cnt #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] term,
    output logic                  tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign tc = (r_count == term);

endmodule
`default_nettype wire

// File: rtl/test_host.sv
`default_nettype none
// =============================================================================
// Module      : test_host
// Description : Sequences memory preload, CPU start/run, and result read-back.
// Revision    : 1.0 - initial release
// =============================================================================
module test_host
    import host_pkg::*;
#(
    parameter logic [7:0] LOAD_BASE = c_load_base_dflt,
    parameter int         LOAD_LEN  = c_load_len_dflt,
    parameter logic [7:0] RES_BASE  = c_res_base_dflt,
    parameter int         RES_LEN   = c_res_len_dflt,
    parameter int         START_CYC = c_start_cyc_dflt,
    parameter int         TIMEOUT   = c_timeout_dflt
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    test_host_if.master bus
);

    localparam logic [7:0]  c_load_last  = 8'(LOAD_LEN - 1);
    localparam logic [7:0]  c_res_last   = 8'(RES_LEN - 1);
    localparam logic [15:0] c_start_last = 16'(START_CYC - 1);
    localparam logic [15:0] c_run_last   = 16'(TIMEOUT - 1);
    localparam host_state_t c_after_idle = (LOAD_LEN > 0) ? LOAD : START;
    localparam host_state_t c_after_halt = (RES_LEN > 0) ? RD : FIN;

    host_state_t r_state, w_next;
    logic [7:0]  r_idx, w_idx_next;
    logic [7:0]  r_res_data;
    logic        r_timeout, w_timeout_next;
    logic        w_cnt_load, w_cnt_en, w_cnt_tc;
    logic [15:0] w_cnt_term;
    logic        w_ld_hs;

    assign w_ld_hs = (r_state == LOAD) && bus.ld_valid;

    // One counter times both the START pulse and the RUN window; it is held
    // at zero outside those states and reloaded at the START->RUN boundary.
    host_cnt #(.WIDTH(16)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (16'd0),
        .en       (w_cnt_en),
        .term     (w_cnt_term),
        .tc       (w_cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_timeout  <= 1'b0;
            r_res_data <= '0;
        end else begin
            r_state   <= w_next;
            r_idx     <= w_idx_next;
            r_timeout <= w_timeout_next;
            if (r_state == CAP) begin
                r_res_data <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_idx_next     = r_idx;
        w_timeout_next = r_timeout;
        w_cnt_load     = 1'b1;
        w_cnt_en       = 1'b0;
        w_cnt_term     = c_start_last;
        case (r_state)
            IDLE: begin
                if (bus.go) begin
                    w_idx_next     = '0;
                    w_timeout_next = 1'b0;
                    w_next         = c_after_idle;
                end
            end
            LOAD: begin
                if (w_ld_hs) begin
                    if (r_idx == c_load_last) begin
                        w_idx_next = '0;
                        w_next     = START;
                    end else begin
                        w_idx_next = r_idx + 8'd1;
                    end
                end
            end
            START: begin
                w_cnt_load = 1'b0;
                w_cnt_en   = 1'b1;
                if (w_cnt_tc) begin
                    w_cnt_load = 1'b1;
                    w_next     = RUN;
                end
            end
            RUN: begin
                w_cnt_load = 1'b0;
                w_cnt_en   = 1'b1;
                w_cnt_term = c_run_last;
                // A halt coinciding with the final window cycle wins.
                if (bus.halt) begin
                    w_next = c_after_halt;
                end else if (w_cnt_tc) begin
                    w_timeout_next = 1'b1;
                    w_next         = FIN;
                end
            end
            RD:  w_next = CAP;
            CAP: w_next = OUT;
            OUT: begin
                if (bus.res_ready) begin
                    if (r_idx == c_res_last) begin
                        w_idx_next = '0;
                        w_next     = FIN;
                    end else begin
                        w_idx_next = r_idx + 8'd1;
                        w_next     = RD;
                    end
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign bus.ld_ready  = (r_state == LOAD);
    assign bus.mem_we    = w_ld_hs;
    assign bus.mem_re    = (r_state == RD);
    assign bus.mem_addr  = (r_state == LOAD) ? (LOAD_BASE + r_idx) :
                           (r_state == RD)   ? (RES_BASE + r_idx)  : 8'h00;
    assign bus.mem_wdata = (r_state == LOAD) ? bus.ld_data : 8'h00;
    assign bus.start     = (r_state == START);
    assign bus.res_valid = (r_state == OUT);
    assign bus.res_data  = r_res_data;
    assign bus.busy      = (r_state != IDLE) && (r_state != FIN);
    assign bus.done      = (r_state == FIN);
    assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire
